// File: rtl/uio_byte_tx.sv
// -----------------------------------------------------------------------------
// uio_byte_tx
// Byte-stream transmitter over the bidirectional uio bus. Internal logic pushes
// bytes into a small FIFO. For each byte the block enables the pad drivers,
// holds the data for a setup time, and then runs a 4-phase req/ack handshake
// with an off-chip receiver. Between bytes the bus is released (uio_oe = 0).
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active low
//   ena          tile enable; 0 = start no new transfer
//   in_data      byte to transmit
//   in_valid     in_data valid
//   in_ready     FIFO can accept (= !full)
//   tx_ack       receiver acknowledge (asynchronous, synchronised inside)
//   tx_req       data-valid request to receiver
//   uio_out      data driven on the uio pads
//   uio_oe       pad output enable, 8'hFF or 8'h00 only
//   timeout_err  sticky: a handshake timed out since reset
// -----------------------------------------------------------------------------
module uio_byte_tx #(
  parameter int DEPTH        = 4,    // FIFO entries, power of 2, 2..16
  parameter int SETUP_CYCLES = 1,    // data-to-req setup cycles, 1..15
  parameter int TIMEOUT      = 255   // max cycles per ack edge, 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       tx_ack,
  output logic       tx_req,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_RELEASE
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  // A pop in the same cycle does not let a full FIFO accept.
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked solely by
  // r_count, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // tx_ack synchroniser
  // ---------------------------------------------------------------------------
  logic r_ack_m;
  logic r_ack_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack_m <= 1'b0;
      r_ack_s <= 1'b0;
    end else begin
      r_ack_m <= tx_ack;
      r_ack_s <= r_ack_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM (all outputs registered)
  // ---------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_setup_cnt;
  logic [3:0] w_setup_cnt_nxt;
  logic [7:0] r_to_cnt;
  logic [7:0] w_to_cnt_nxt;
  logic       r_tx_req;
  logic       w_tx_req_nxt;
  logic       r_oe;
  logic       w_oe_nxt;
  logic [7:0] r_uio_out;
  logic [7:0] w_uio_out_nxt;
  logic       r_timeout_err;
  logic       w_timeout_err_nxt;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_setup_cnt_nxt   = r_setup_cnt;
    w_to_cnt_nxt      = r_to_cnt;
    w_tx_req_nxt      = r_tx_req;
    w_oe_nxt          = r_oe;
    w_uio_out_nxt     = r_uio_out;
    w_timeout_err_nxt = r_timeout_err;
    w_pop             = 1'b0;

    case (r_state)
      S_IDLE: begin
        // The single IDLE cycle after a release is the bus turnaround.
        if (!w_empty && ena) begin
          w_uio_out_nxt   = w_head;
          w_oe_nxt        = 1'b1;
          w_setup_cnt_nxt = 4'(SETUP_CYCLES);
          w_state_nxt     = S_SETUP;
        end
      end

      S_SETUP: begin
        // Raising req on the cycle the counter would hit zero gives exactly
        // SETUP_CYCLES cycles of driven data before tx_req is seen high.
        if (r_setup_cnt == 4'd1) begin
          w_setup_cnt_nxt = 4'd0;
          w_tx_req_nxt    = 1'b1;
          w_to_cnt_nxt    = 8'd0;
          w_state_nxt     = S_REQ;
        end else begin
          w_setup_cnt_nxt = r_setup_cnt - 4'd1;
        end
      end

      S_REQ: begin
        if (r_ack_s) begin
          w_tx_req_nxt = 1'b0;
          w_pop        = 1'b1;
          w_to_cnt_nxt = 8'd0;
          w_state_nxt  = S_RELEASE;
        end else if (r_to_cnt == TO_LAST) begin
          // Unacknowledged byte is dropped so the queue cannot wedge.
          w_tx_req_nxt      = 1'b0;
          w_oe_nxt          = 1'b0;
          w_timeout_err_nxt = 1'b1;
          w_pop             = 1'b1;
          w_state_nxt       = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 8'd1;
        end
      end

      S_RELEASE: begin
        if (!r_ack_s) begin
          w_oe_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_tx_req_nxt      = 1'b0;
          w_oe_nxt          = 1'b0;
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 8'd1;
        end
      end

      default: begin
        w_tx_req_nxt = 1'b0;
        w_oe_nxt     = 1'b0;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_setup_cnt   <= 4'd0;
      r_to_cnt      <= 8'd0;
      r_tx_req      <= 1'b0;
      r_oe          <= 1'b0;
      r_uio_out     <= 8'h00;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_setup_cnt   <= w_setup_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_tx_req      <= w_tx_req_nxt;
      r_oe          <= w_oe_nxt;
      r_uio_out     <= w_uio_out_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign tx_req      = r_tx_req;
  assign uio_out     = r_uio_out;
  assign uio_oe      = {8{r_oe}};
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uio_byte_tx.sv
// -----------------------------------------------------------------------------
// tb_uio_byte_tx
// Directed bench for uio_byte_tx (DEPTH=4, SETUP_CYCLES=1, TIMEOUT=16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_uio_byte_tx;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx_ack;
  logic       tx_req;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  uio_byte_tx #(
    .DEPTH       (4),
    .SETUP_CYCLES(1),
    .TIMEOUT     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_ack     (tx_ack),
    .tx_req     (tx_req),
    .uio_out    (uio_out),
    .uio_oe     (uio_oe),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Full 4-phase handshake for one byte, each wait bounded to 20 cycles.
  task automatic handshake(input string tag, input logic [7:0] exp_byte);
    int n;
    n = 0;
    while (tx_req !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_req_hi"}, {7'd0, tx_req}, 8'h01);
    check({tag, "_data"}, uio_out, exp_byte);
    check({tag, "_oe_on"}, uio_oe, 8'hFF);
    tx_ack = 1'b1;
    n = 0;
    while (tx_req !== 1'b0 && n < 20) begin tick(); n++; end
    check({tag, "_req_lo"}, {7'd0, tx_req}, 8'h00);
    tx_ack = 1'b0;
    n = 0;
    while (uio_oe !== 8'h00 && n < 20) begin tick(); n++; end
    check({tag, "_oe_off"}, uio_oe, 8'h00);
  endtask

  initial begin
    logic seen;
    rst_n    = 1'b0;
    ena      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    tx_ack   = 1'b0;

    // 1: reset state
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_oe", uio_oe, 8'h00);
    check("rst_req", {7'd0, tx_req}, 8'h00);
    check("rst_out", uio_out, 8'h00);
    check("rst_err", {7'd0, timeout_err}, 8'h00);
    check("rst_ready", {7'd0, in_ready}, 8'h01);

    // 2: single byte, exact latencies
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();                                   // edge N: push
    in_valid = 1'b0;
    check("t2_oe_n", uio_oe, 8'h00);
    tick();                                   // edge N+1: drive
    check("t2_out", uio_out, 8'hA5);
    check("t2_oe", uio_oe, 8'hFF);
    check("t2_req_n1", {7'd0, tx_req}, 8'h00);
    tick();                                   // edge N+2: req
    check("t2_req", {7'd0, tx_req}, 8'h01);
    tx_ack = 1'b1;
    tick();
    tick();
    check("t2_req_hold", {7'd0, tx_req}, 8'h01);
    tick();
    check("t2_req_drop", {7'd0, tx_req}, 8'h00);
    check("t2_oe_hold", uio_oe, 8'hFF);
    tx_ack = 1'b0;
    tick();
    tick();
    check("t2_oe_hold2", uio_oe, 8'hFF);
    tick();
    check("t2_oe_rel", uio_oe, 8'h00);

    // 3: fill FIFO, fifth byte refused, in-order drain
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = 8'(i);
      tick();
      if (i == 4) check("t3_full", {7'd0, in_ready}, 8'h00);
    end
    in_valid = 1'b0;
    check("t3_refuse", {7'd0, in_ready}, 8'h00);
    handshake("t3_b1", 8'h01);
    handshake("t3_b2", 8'h02);
    handshake("t3_b3", 8'h03);
    handshake("t3_b4", 8'h04);
    check("t3_ready", {7'd0, in_ready}, 8'h01);
    repeat (5) tick();
    check("t3_no05", uio_oe, 8'h00);

    // 4: timeout
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t4_req", {7'd0, tx_req}, 8'h01);
    repeat (15) tick();
    check("t4_req_15", {7'd0, tx_req}, 8'h01);
    tick();
    check("t4_req_to", {7'd0, tx_req}, 8'h00);
    check("t4_oe_to", uio_oe, 8'h00);
    check("t4_err", {7'd0, timeout_err}, 8'h01);
    in_data  = 8'h7E;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    handshake("t4_7e", 8'h7E);
    check("t4_err_sticky", {7'd0, timeout_err}, 8'h01);

    // 5: ena=0 mid-transfer
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick();
    in_data  = 8'h22;
    tick();
    in_valid = 1'b0;
    tick();
    check("t5_req", {7'd0, tx_req}, 8'h01);
    ena = 1'b0;
    handshake("t5_b1", 8'h11);
    repeat (5) tick();
    check("t5_hold_oe", uio_oe, 8'h00);
    check("t5_hold_req", {7'd0, tx_req}, 8'h00);
    ena = 1'b1;
    tick();
    check("t5_b2_out", uio_out, 8'h22);
    check("t5_b2_oe", uio_oe, 8'hFF);
    handshake("t5_b2", 8'h22);

    // 6: reset mid-transfer
    in_valid = 1'b1;
    in_data  = 8'h31;
    tick();
    in_data  = 8'h32;
    tick();
    in_data  = 8'h33;
    tick();
    in_valid = 1'b0;
    check("t6_req", {7'd0, tx_req}, 8'h01);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_req_rst", {7'd0, tx_req}, 8'h00);
    check("t6_oe_rst", uio_oe, 8'h00);
    check("t6_err_rst", {7'd0, timeout_err}, 8'h00);
    check("t6_ready", {7'd0, in_ready}, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (uio_oe !== 8'h00 || tx_req !== 1'b0) seen = 1'b1;
    end
    check("t6_quiet", {7'd0, seen}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
